mem_access_unit: RTL and testbench

Memory-stage load/store engine of the P6 pipeline, directly downstream of the ALU: takes the ALU result as the effective address plus the store operand, drives a word-addressed data-memory port through a request/grant/response handshake, and returns sign- or zero-extended load data to the W-stage path. While an access is outstanding, it asserts `stall` to freeze the upstream pipeline.

---
 rtl/mem_access_unit_pkg.sv | 57 +++++
 rtl/mem_access_unit_load_extender.sv | 34 +++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared globals for the M-stage load/store engine: memory op encodings,
// FSM state encodings and small op-classification helpers.
package mem_access_unit_pkg;

    // Memory op encodings carried down the pipeline (4 bits)
    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LW   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LHU  = 4'd3;
    localparam logic [3:0] MEM_LB   = 4'd4;
    localparam logic [3:0] MEM_LBU  = 4'd5;
    localparam logic [3:0] MEM_SW   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SB   = 4'd8;

    // Access FSM states (2 bits)
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2,
        MS_DONE = 2'd3
    } mem_state_e;

    function automatic logic is_load_op(input logic [3:0] op);
        return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LHU) ||
               (op == MEM_LB) || (op == MEM_LBU);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

    // Word ops need both low bits clear, half ops need bit 0 clear
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_LW, MEM_SW:          mis = (addr_lo != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: mis = addr_lo[0];
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Force the low address bits to the natural alignment of the op
    function automatic logic [31:0] align_addr(input logic [3:0] op, input logic [31:0] addr);
        logic [31:0] a;
        a = addr;
        case (op)
            MEM_LW, MEM_SW:          a = {addr[31:2], 2'b00};
            MEM_LH, MEM_LHU, MEM_SH: a = {addr[31:1], 1'b0};
            default:                 a = addr;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// load_extender: picks the addressed byte or halfword out of the raw memory
// word and sign- or zero-extends it to 32 bits; word loads pass through.
module load_extender
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension according to the load type
    always_comb begin
        byte_sel = 8'h00;
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
        case (addr_lo)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        case (op)
            MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data = {24'h000000, byte_sel};
            MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data = {16'h0000, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store engine. Latches one access from the
// pipeline, runs it over a req/gnt/rvalid memory port and returns extended
// load data with a one-cycle done pulse, stalling upstream meanwhile.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned accesses are not
// issued and raise exc_adel/exc_ades; without it the low address bits are
// forced to natural alignment and the exception outputs stay 0.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        m_req,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    mem_state_e  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        squash_q, squash_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        addr_err;
    logic [31:0] ext_data;
    logic        op_is_load;
    logic        op_is_store;

    load_extender u_load_extender (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .raw     (m_rdata),
        .data    (ext_data)
    );

    // Alignment error for the incoming op, only when checking is built in
    always_comb begin
        addr_err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        addr_err = is_misaligned(op, addr[1:0]);
`endif
    end

    // Next-state logic: accept in IDLE, handshake in REQ/WAIT, pulse in DONE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        squash_d = squash_q;
        rdata_d  = rdata_q;
        accept   = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (req_valid && !flush && (is_load_op(op) || is_store_op(op))) begin
                    accept   = 1'b1;
                    op_d     = op;
                    addr_d   = align_addr(op, addr);
                    wdata_d  = wdata;
                    err_d    = addr_err;
                    squash_d = 1'b0;
                    state_d  = addr_err ? MS_DONE : MS_REQ;
                end
            end
            MS_REQ: begin
                if (m_gnt) begin
                    // Once granted the access is in flight; a flush only squashes the result
                    squash_d = flush;
                    state_d  = is_store_op(op_q) ? MS_DONE : MS_WAIT;
                end else if (flush) begin
                    state_d = MS_IDLE;
                end
            end
            MS_WAIT: begin
                if (flush) begin
                    squash_d = 1'b1;
                end
                if (m_rvalid) begin
                    if (!(squash_q || flush)) begin
                        rdata_d = ext_data;
                    end
                    state_d = MS_DONE;
                end
            end
            default: begin
                state_d  = MS_IDLE;
                err_d    = 1'b0;
                squash_d = 1'b0;
            end
        endcase
    end

    // State and latched-access registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MS_IDLE;
            op_q     <= MEM_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            squash_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            squash_q <= squash_d;
            rdata_q  <= rdata_d;
        end
    end

    // Memory port drive: held constant from the latched access while in REQ
    always_comb begin
        op_is_load  = is_load_op(op_q);
        op_is_store = is_store_op(op_q);
        m_req    = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_byteen = 4'b0000;
        m_wdata  = '0;
        if (state_q == MS_REQ) begin
            m_req  = 1'b1;
            m_wr   = op_is_store;
            m_addr = {addr_q[31:2], 2'b00};
            case (op_q)
                MEM_SB: begin
                    m_byteen = 4'b0001 << addr_q[1:0];
                    m_wdata  = {4{wdata_q[7:0]}};
                end
                MEM_SH: begin
                    m_byteen = 4'b0011 << {addr_q[1], 1'b0};
                    m_wdata  = {2{wdata_q[15:0]}};
                end
                MEM_SW: begin
                    m_byteen = 4'b1111;
                    m_wdata  = wdata_q;
                end
                default: begin
                    m_byteen = 4'b0000;
                    m_wdata  = '0;
                end
            endcase
        end
    end

    // Pipeline-facing status: stall, completion pulse and exceptions
    always_comb begin
        stall       = accept || (state_q == MS_REQ) || (state_q == MS_WAIT);
        done        = (state_q == MS_DONE) && !squash_q;
        rdata_valid = done && op_is_load && !err_q;
        rdata       = rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
        exc_adel    = done && err_q && op_is_load;
        exc_ades    = done && err_q && op_is_store;
`else
        exc_adel    = 1'b0;
        exc_ades    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: random and directed load/store traffic
// against a byte-array reference memory, with a response scoreboard and a
// memory-side responder that applies random grant/read-data delays.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, req_valid, flush;
    logic [3:0]  op;
    logic [31:0] addr, wdata;
    logic        stall, done, rdata_valid, exc_adel, exc_ades;
    logic [31:0] rdata;
    logic        m_req, m_wr, m_gnt, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_byteen;

    mem_access_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .op          (op),
        .addr        (addr),
        .wdata       (wdata),
        .flush       (flush),
        .stall       (stall),
        .done        (done),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .exc_adel    (exc_adel),
        .exc_ades    (exc_ades),
        .m_req       (m_req),
        .m_wr        (m_wr),
        .m_addr      (m_addr),
        .m_byteen    (m_byteen),
        .m_wdata     (m_wdata),
        .m_gnt       (m_gnt),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          rv;
        logic [31:0] data;
        bit          adel;
        bit          ades;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } acc_t;

    exp_t        exp_q[$];
    acc_t        cur_acc;
    bit          cur_acc_valid = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          g_gnt_delay = 0;
    int          g_rv_delay = 0;
    logic [31:0] last_rdata = '0;
    logic [7:0]  ref_mem [0:63];
    logic [31:0] mem_words [0:15];
    logic [3:0]  ops [0:7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic failNow(input string nm);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic int op_size(input logic [3:0] o);
        if (o == MEM_LW || o == MEM_SW) return 4;
        if (o == MEM_LH || o == MEM_LHU || o == MEM_SH) return 2;
        return 1;
    endfunction

    function automatic bit op_is_ld(input logic [3:0] o);
        return (o == MEM_LW || o == MEM_LH || o == MEM_LHU || o == MEM_LB || o == MEM_LBU);
    endfunction

    // Little-endian read of sz bytes from the reference memory, then extension
    function automatic logic [31:0] model_load(input logic [3:0] o, input logic [31:0] aa);
        int sz = op_size(o);
        logic [31:0] v = '0;
        for (int j = 0; j < sz; j++) v[8*j +: 8] = ref_mem[int'(aa[5:0]) + j];
        if ((o == MEM_LB || o == MEM_LH) && v[8*sz-1])
            for (int j = 8*sz; j < 32; j++) v[j] = 1'b1;
        return v;
    endfunction

    // Memory responder: grants after g_gnt_delay cycles, returns data after g_rv_delay
    initial begin
        int  gcnt = -1;
        bit  rv_pend = 0;
        int  rv_cnt = 0;
        int  rv_idx = 0;
        bit  gnt_prev = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
        forever begin
            @(posedge clk); #2;
            m_gnt = 0;
            m_rvalid = 0;
            if (gnt_prev) begin cur_acc_valid = 0; gnt_prev = 0; end
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    m_rvalid = 1;
                    m_rdata = mem_words[rv_idx];
                    rv_pend = 0;
                end else rv_cnt--;
            end
            if (m_req === 1'b1 && !reset) begin
                if (gcnt < 0) gcnt = g_gnt_delay;
                if (gcnt == 0) begin
                    m_gnt = 1;
                    gnt_prev = 1;
                    gcnt = -1;
                    if (m_wr) begin
                        for (int i = 0; i < 4; i++)
                            if (m_byteen[i]) mem_words[m_addr[5:2]][8*i +: 8] = m_wdata[8*i +: 8];
                    end else begin
                        rv_pend = 1;
                        rv_cnt = g_rv_delay;
                        rv_idx = int'(m_addr[5:2]);
                    end
                end else gcnt--;
            end else gcnt = -1;
        end
    end

    // Monitor: pops the scoreboard on every done and checks the memory port
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) failNow("unexpected_done");
            else begin
                e = exp_q.pop_front();
                checkOutput("done_cycle", cyc, e.due);
                checkOutput("rdata_valid", {31'b0, rdata_valid}, {31'b0, e.rv});
                if (e.rv) checkOutput("rdata", rdata, e.data);
                checkOutput("exc_adel", {31'b0, exc_adel}, {31'b0, e.adel});
                checkOutput("exc_ades", {31'b0, exc_ades}, {31'b0, e.ades});
            end
            if (rdata_valid === 1'b1) last_rdata = rdata;
        end else if (rdata_valid === 1'b1 || exc_adel === 1'b1 || exc_ades === 1'b1) begin
            failNow("pulse_without_done");
        end
        if (m_req === 1'b1) begin
            if (!cur_acc_valid) failNow("unexpected_m_req");
            else begin
                checkOutput("m_wr", {31'b0, m_wr}, {31'b0, cur_acc.wr});
                checkOutput("m_addr", m_addr, cur_acc.addr);
                checkOutput("m_byteen", {28'b0, m_byteen}, {28'b0, cur_acc.be});
                if (cur_acc.wr) checkOutput("m_wdata", m_wdata, cur_acc.wd);
            end
        end
    end

    // Presents one access for one cycle and records the model's expectations
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                         input int gd, input int rd, input bit expect_done, output int exp_stall);
        int          sz  = op_size(o);
        bit          ld  = op_is_ld(o);
        logic [31:0] msk = sz - 1;
        logic [31:0] aa  = a & ~msk;
        bit          err = CHECK_EN && ((a & msk) != 0);
        exp_t        e;
        acc_t        c;
        g_gnt_delay = gd;
        g_rv_delay  = rd;
        if (!err) begin
            c.wr   = !ld;
            c.addr = aa & ~32'h3;
            c.be   = 4'b0000;
            c.wd   = '0;
            if (!ld) begin
                for (int j = 0; j < sz; j++) c.be[int'(aa[1:0]) + j] = 1'b1;
                for (int i = 0; i < 4; i++) c.wd[8*i +: 8] = w[8*(i % sz) +: 8];
                for (int j = 0; j < sz; j++) ref_mem[int'(aa[5:0]) + j] = w[8*j +: 8];
            end
            cur_acc = c;
            cur_acc_valid = 1;
        end
        exp_stall = err ? 0 : (ld ? 2 + gd + rd : 1 + gd);
        e.due  = cyc + (err ? 1 : (ld ? 3 + gd + rd : 2 + gd));
        e.rv   = ld && !err;
        e.data = (ld && !err) ? model_load(o, aa) : '0;
        e.adel = err && ld;
        e.ades = err && !ld;
        if (expect_done) exp_q.push_back(e);
        req_valid = 1; op = o; addr = a; wdata = w;
        @(negedge clk);
        checkOutput("stall_on_accept", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        req_valid = 0; op = MEM_NONE; addr = '0; wdata = '0;
    endtask

    // Counts stall cycles until release, optionally pulsing flush/reset at cycle offsets
    task automatic waitIdle(input int exp_stall, input int flush_at, input int reset_at);
        int k = 1;
        int cnt = 0;
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            flush = (k == flush_at);
            reset = (k == reset_at);
            @(negedge clk);
            if (stall === 1'b0) begin ok = 1; break; end
            cnt++;
            @(posedge clk); #1;
            k++;
        end
        flush = 0;
        reset = 0;
        if (!ok) failNow("stall_timeout");
        else checkOutput("stall_cycles", cnt, exp_stall);
        @(posedge clk); #1;
        cur_acc_valid = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                                 input int gd, input int rd);
        int es;
        issue(o, a, w, gd, rd, 1'b1, es);
        waitIdle(es, 0, 0);
    endtask

    initial begin
        int es;
        ops = '{MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU, MEM_SW, MEM_SH, MEM_SB};
        reset = 1; req_valid = 0; op = MEM_NONE; addr = '0; wdata = '0; flush = 0;
        for (int i = 0; i < 16; i++) mem_words[i] = $urandom;
        mem_words[0] = 32'h80FF_1234;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = mem_words[i][8*j +: 8];

        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
        checkOutput("rst_exc", {30'b0, exc_adel, exc_ades}, 32'd0);
        checkOutput("rst_m_req", {31'b0, m_req}, 32'd0);
        checkOutput("rst_m_wr", {31'b0, m_wr}, 32'd0);
        checkOutput("rst_m_byteen", {28'b0, m_byteen}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_m_addr", m_addr, 32'd0);
        checkOutput("rst_m_wdata", m_wdata, 32'd0);
        @(posedge clk); #1;

        $display("[TB] directed loads/stores");
        applyStimulus(MEM_LB, 32'h0000_0003, 32'h0, 0, 0);
        checkOutput("lb_signext", last_rdata, 32'hFFFF_FF80);
        applyStimulus(MEM_LBU, 32'h0000_0003, 32'h0, 0, 0);
        checkOutput("lbu_zeroext", last_rdata, 32'h0000_0080);
        applyStimulus(MEM_SH, 32'h0000_0002, 32'h1234_ABCD, 2, 0);
        applyStimulus(MEM_LW, 32'h0000_0000, 32'h0, 1, 1);
        checkOutput("sh_then_lw", last_rdata, 32'hABCD_1234);
        applyStimulus(MEM_LW, 32'h0000_0006, 32'h0, 0, 0);

        $display("[TB] flush and reset scenarios");
        issue(MEM_LW, 32'h0000_0010, 32'h0, 0, 3, 1'b0, es);
        waitIdle(5, 2, 0);
        issue(MEM_LW, 32'h0000_0020, 32'h0, 3, 0, 1'b0, es);
        waitIdle(1, 1, 0);
        issue(MEM_LW, 32'h0000_0024, 32'h0, 3, 0, 1'b0, es);
        waitIdle(1, 0, 1);
        @(negedge clk);
        checkOutput("reset_in_req_m_req", {31'b0, m_req}, 32'd0);
        checkOutput("reset_in_req_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        issue(MEM_LW, 32'h0000_0028, 32'h0, 0, 3, 1'b0, es);
        waitIdle(2, 0, 2);
        checkOutput("rdata_after_reset", rdata, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("idle_after_late_rvalid", {31'b0, stall}, 32'd0);
        end
        @(posedge clk); #1;

        req_valid = 1; op = MEM_LW; addr = 32'h4; flush = 1;
        @(negedge clk);
        checkOutput("flushed_req_no_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1; op = MEM_NONE; flush = 0;
        @(negedge clk);
        checkOutput("flushed_req_no_m_req", {31'b0, m_req}, 32'd0);
        checkOutput("none_op_no_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        req_valid = 0;

        $display("[TB] random traffic");
        for (int n = 0; n < 80; n++) begin
            applyStimulus(ops[$urandom_range(0, 7)], $urandom, $urandom,
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
